// File: rtl/sw_req_ctrl_pkg.sv
// Shared types and helpers for the switch requester controller.
// The arbiter interface carries a 2-bit priority pointer for all widths.
package sw_req_ctrl_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int LOW_PR_W       = 2;
    localparam int CREDIT_MAX_DEF = 4;

    // Index of the set bit in a one-hot vector of up to four bits.
    function automatic logic [LOW_PR_W-1:0] onehot_to_idx(input logic [3:0] oh);
        logic [LOW_PR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = LOW_PR_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sw_req_ctrl_credit_cnt_sat.sv
// Saturating downstream credit counter with a sticky overflow flag.
// Simultaneous increment and decrement leave the count unchanged.
module credit_cnt_sat #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    logic [W-1:0] cnt_reg;
    logic         ovf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= W'(MAX);
            ovf_reg <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: begin
                    if (cnt_reg == W'(MAX)) ovf_reg <= 1'b1;
                    else                    cnt_reg <= cnt_reg + W'(1);
                end
                2'b01: begin
                    if (cnt_reg != '0) cnt_reg <= cnt_reg - W'(1);
                end
                default: ;
            endcase
        end
    end

    assign cnt = cnt_reg;
    assign ovf = ovf_reg;

endmodule

// File: rtl/sw_req_ctrl.sv
// Requester side of a one-hot round-robin switch arbiter: raises requests,
// owns the priority pointer, holds wormhole lock and gates on credits.
module sw_req_ctrl
    import sw_req_ctrl_pkg::*;
#(
    parameter int V          = 4,
    parameter int CREDIT_MAX = CREDIT_MAX_DEF,
    parameter int CRED_W     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [V-1:0]        vc_valid,
    input  logic [V-1:0]        vc_head,
    input  logic [V-1:0]        vc_tail,
    output logic [V-1:0]        arb_req,
    input  logic [V-1:0]        arb_grant,
    output logic [LOW_PR_W-1:0] low_pr,
    output logic [V-1:0]        vc_pop,
    output logic                out_valid,
    output logic [V-1:0]        out_vc,
    input  logic                credit_in,
    output logic [CRED_W-1:0]   credit_cnt,
    output logic                grant_err,
    output logic                credit_err
);

    state_t              state_reg;
    logic [LOW_PR_W-1:0] owner_reg;
    logic [LOW_PR_W-1:0] low_pr_reg;
    logic                grant_err_reg;

    logic                cred_ok;
    logic [V-1:0]        idle_req;
    logic [V-1:0]        owner_oh;
    logic                grant_onehot;
    logic                grant_legal;
    logic [V-1:0]        req_next;
    logic [V-1:0]        pop_next;
    logic                pop_tail;
    logic                pop_head;
    logic [LOW_PR_W-1:0] grant_idx;

    assign cred_ok      = (credit_cnt != '0);
    assign idle_req     = vc_valid & vc_head & {V{cred_ok}};
    assign owner_oh     = V'(1) << owner_reg;
    assign grant_onehot = (arb_grant != '0) && ((arb_grant & (arb_grant - V'(1))) == '0);
    // Legal grants are a subset of the request, so they imply credit is available.
    assign grant_legal  = grant_onehot && ((arb_grant & ~idle_req) == '0);
    assign grant_idx    = onehot_to_idx(4'(arb_grant));

    always_comb begin
        req_next = '0;
        pop_next = '0;
        if (state_reg == IDLE) begin
            req_next = idle_req;
            if (grant_legal) pop_next = arb_grant;
        end else if (((vc_valid & owner_oh) != '0) && cred_ok) begin
            pop_next = owner_oh;
        end
    end

    assign pop_tail = |(pop_next & vc_tail);
    assign pop_head = |(pop_next & vc_head);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            low_pr_reg    <= LOW_PR_W'(V - 1);
            grant_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_legal) begin
                        low_pr_reg <= grant_idx;
                        if (!pop_tail) begin
                            state_reg <= LOCKED;
                            owner_reg <= grant_idx;
                        end
                    end else if (arb_grant != '0) begin
                        grant_err_reg <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (pop_next != '0) begin
                        // A head flit inside a locked packet is still forwarded.
                        if (pop_head) grant_err_reg <= 1'b1;
                        if (pop_tail) state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    credit_cnt_sat #(
        .MAX (CREDIT_MAX),
        .W   (CRED_W)
    ) u_credit (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (credit_in),
        .dec   (|pop_next),
        .cnt   (credit_cnt),
        .ovf   (credit_err)
    );

    // Combinational strobes are held low while reset is asserted.
    assign arb_req   = rst_n ? req_next : '0;
    assign vc_pop    = rst_n ? pop_next : '0;
    assign out_vc    = vc_pop;
    assign out_valid = |vc_pop;
    assign low_pr    = low_pr_reg;
    assign grant_err = grant_err_reg;

endmodule

// File: tb/tb_sw_req_ctrl.sv
// Scoreboard bench for sw_req_ctrl with a behavioural round-robin arbiter
// and a packet-level reference model driven by per-VC flit queues.
module tb_sw_req_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] vc_valid, vc_head, vc_tail;
    logic [3:0] arb_req, arb_grant, vc_pop, out_vc;
    logic [1:0] low_pr;
    logic       out_valid, credit_in;
    logic [2:0] credit_cnt;
    logic       grant_err, credit_err;
    logic       force_en;
    logic [3:0] force_g;

    always #5 clk = ~clk;

    sw_req_ctrl #(.V(4), .CREDIT_MAX(4), .CRED_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vc_valid   (vc_valid),
        .vc_head    (vc_head),
        .vc_tail    (vc_tail),
        .arb_req    (arb_req),
        .arb_grant  (arb_grant),
        .low_pr     (low_pr),
        .vc_pop     (vc_pop),
        .out_valid  (out_valid),
        .out_vc     (out_vc),
        .credit_in  (credit_in),
        .credit_cnt (credit_cnt),
        .grant_err  (grant_err),
        .credit_err (credit_err)
    );

    // Round-robin pick: first requester after the lowest-priority index.
    function automatic int rr_pick(input logic [3:0] req, input int lp);
        for (int k = 1; k <= 4; k++) begin
            if (req[(lp + k) % 4]) return (lp + k) % 4;
        end
        return -1;
    endfunction

    always_comb begin
        arb_grant = 4'b0000;
        if (force_en)            arb_grant = force_g;
        else if (arb_req != 4'b0) arb_grant = 4'(1 << rr_pick(arb_req, int'(low_pr)));
    end

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] pop;
        logic       ov;
        logic [2:0] cnt;
        logic [1:0] lp;
        logic       ge;
        logic       ce;
    } snap_t;

    snap_t      exp_q[$];
    logic [1:0] fq0[$], fq1[$], fq2[$], fq3[$];   // {head, tail} per flit

    int m_owner, m_lp, m_cred;
    bit m_ge, m_ce;
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = -1; m_lp = 3; m_cred = 4; m_ge = 1'b0; m_ce = 1'b0;
    endtask

    function automatic int qsize(input int i);
        case (i)
            0: return fq0.size();
            1: return fq1.size();
            2: return fq2.size();
            default: return fq3.size();
        endcase
    endfunction

    function automatic logic [1:0] qfront(input int i);
        case (i)
            0: return fq0[0];
            1: return fq1[0];
            2: return fq2[0];
            default: return fq3[0];
        endcase
    endfunction

    task automatic qpop(input int i);
        logic [1:0] d;
        case (i)
            0: d = fq0.pop_front();
            1: d = fq1.pop_front();
            2: d = fq2.pop_front();
            default: d = fq3.pop_front();
        endcase
    endtask

    task automatic qpush(input int i, input logic [1:0] f);
        case (i)
            0: fq0.push_back(f);
            1: fq1.push_back(f);
            2: fq2.push_back(f);
            default: fq3.push_back(f);
        endcase
    endtask

    // Packet of len flits on VC i: head on first, tail on last.
    task automatic push_pkt(input int i, input int len);
        for (int n = 0; n < len; n++)
            qpush(i, {n == 0, n == len - 1});
    endtask

    task automatic step(input bit cin, input bit fen, input logic [3:0] fg);
        logic [3:0] v, h, t, g;
        snap_t      e;
        int         idx;
        bit         legal;
        @(posedge clk); #1;
        v = '0; h = '0; t = '0;
        for (int i = 0; i < 4; i++) begin
            if (qsize(i) > 0) begin
                v[i] = 1'b1;
                {h[i], t[i]} = qfront(i);
            end
        end
        vc_valid = v; vc_head = h; vc_tail = t;
        credit_in = cin; force_en = fen; force_g = fg;

        e = '0;
        e.cnt = 3'(m_cred); e.lp = 2'(m_lp); e.ge = m_ge; e.ce = m_ce;
        if (m_owner < 0) begin
            if (m_cred > 0) e.req = v & h;
            if (fen)                g = fg;
            else if (e.req != 4'b0) g = 4'(1 << rr_pick(e.req, m_lp));
            else                    g = 4'b0;
            legal = ($countones(g) == 1) && ((g & ~e.req) == 4'b0);
            if (legal) begin
                idx = rr_pick(g, 3);
                e.pop = g;
                m_lp = idx;
                if (!t[idx]) m_owner = idx;
            end else if (g != 4'b0) begin
                m_ge = 1'b1;
            end
        end else if (v[m_owner] && m_cred > 0) begin
            e.pop = 4'(1 << m_owner);
            if (h[m_owner]) m_ge = 1'b1;
            if (t[m_owner]) m_owner = -1;
        end
        e.ov = (e.pop != 4'b0);
        if (e.ov && !cin)      m_cred--;
        else if (cin && !e.ov) begin
            if (m_cred == 4) m_ce = 1'b1;
            else             m_cred++;
        end
        for (int i = 0; i < 4; i++) if (e.pop[i]) qpop(i);
        exp_q.push_back(e);
    endtask

    task automatic drain(input bit cin);
        for (int n = 0; n < 60; n++) begin
            if (qsize(0) + qsize(1) + qsize(2) + qsize(3) == 0 && m_owner < 0) break;
            step(cin, 1'b0, 4'b0);
        end
    endtask

    snap_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("arb_req",    int'(arb_req),    int'(mon_e.req));
            chk("vc_pop",     int'(vc_pop),     int'(mon_e.pop));
            chk("out_vc",     int'(out_vc),     int'(mon_e.pop));
            chk("out_valid",  int'(out_valid),  int'(mon_e.ov));
            chk("credit_cnt", int'(credit_cnt), int'(mon_e.cnt));
            chk("low_pr",     int'(low_pr),     int'(mon_e.lp));
            chk("grant_err",  int'(grant_err),  int'(mon_e.ge));
            chk("credit_err", int'(credit_err), int'(mon_e.ce));
            $display("t=%0t req=%b pop=%b cnt=%0d low_pr=%0d gerr=%0d cerr=%0d",
                     $time, arb_req, vc_pop, credit_cnt, low_pr, grant_err, credit_err);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; vc_valid = '0; vc_head = '0; vc_tail = '0;
        credit_in = 1'b0; force_en = 1'b0; force_g = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_low_pr",     int'(low_pr),     3);
        chk("rst_credit_cnt", int'(credit_cnt), 4);
        chk("rst_arb_req",    int'(arb_req),    0);
        chk("rst_grant_err",  int'(grant_err),  0);
        chk("rst_credit_err", int'(credit_err), 0);
        @(negedge clk); rst_n = 1'b1;

        // Round robin over single-flit packets, credits replenished every cycle.
        for (int i = 0; i < 4; i++) begin
            push_pkt(i, 1);
            push_pkt(i, 1);
        end
        repeat (5) step(1'b1, 1'b0, 4'b0);
        drain(1'b1);

        // Wormhole: VC1 three flits, VC2 head waiting.
        push_pkt(1, 3);
        push_pkt(2, 1);
        drain(1'b1);

        // Credit stall on a 6-flit packet.
        push_pkt(0, 6);
        repeat (8) step(1'b0, 1'b0, 4'b0);
        step(1'b1, 1'b0, 4'b0);
        step(1'b1, 1'b0, 4'b0);
        step(1'b0, 1'b0, 4'b0);
        repeat (4) step(1'b1, 1'b0, 4'b0);
        step(1'b1, 1'b0, 4'b0);

        // Grant errors: zero grant, multi-hot, outside request.
        push_pkt(0, 1);
        push_pkt(1, 1);
        step(1'b0, 1'b1, 4'b0000);
        step(1'b0, 1'b1, 4'b0011);
        step(1'b0, 1'b1, 4'b0100);
        drain(1'b1);

        // Randomised packets and credit returns.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                int vc;
                vc = int'($urandom_range(0, 3));
                if (qsize(vc) < 6) push_pkt(vc, int'($urandom_range(1, 4)));
            end
            step(1'($urandom_range(0, 1)), 1'b0, 4'b0);
        end
        for (int n = 0; n < 100; n++) begin
            if (qsize(0) + qsize(1) + qsize(2) + qsize(3) == 0 && m_owner < 0) break;
            step(1'($urandom_range(0, 1)), 1'b0, 4'b0);
        end
        chk("random_drained", qsize(0) + qsize(1) + qsize(2) + qsize(3), 0);

        // Asynchronous reset while locked on VC2.
        repeat (4) step(1'b1, 1'b0, 4'b0);
        push_pkt(2, 4);
        step(1'b0, 1'b0, 4'b0);
        step(1'b0, 1'b0, 4'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_arb_req",    int'(arb_req),    0);
        chk("arst_vc_pop",     int'(vc_pop),     0);
        chk("arst_out_valid",  int'(out_valid),  0);
        chk("arst_low_pr",     int'(low_pr),     3);
        chk("arst_credit_cnt", int'(credit_cnt), 4);
        chk("arst_grant_err",  int'(grant_err),  0);
        chk("arst_credit_err", int'(credit_err), 0);
        @(posedge clk); #1;
        fq0.delete(); fq1.delete(); fq2.delete(); fq3.delete();
        vc_valid = '0; vc_head = '0; vc_tail = '0; credit_in = 1'b0;
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        push_pkt(3, 1);
        step(1'b0, 1'b0, 4'b0);
        step(1'b0, 1'b0, 4'b0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
